// File: rtl/capture_ctrl.sv
// -----------------------------------------------------------------------------
// capture_ctrl
//
// Sequences one DSO acquisition around the trigger block. Decimated samples are
// written into a circular capture RAM. Once enough pre-trigger samples are stored
// to leave room for the requested post-trigger window, the controller arms the
// trigger logic. After the trigger it counts trig_pos post-trigger samples, then
// freezes the buffer and reports the address of the last sample written.
//
// State sequence: IDLE -> FILL -> WAIT -> POST -> DONE -> IDLE
//   FILL : collecting pre-trigger samples, trigger ignored
//   WAIT : armed, waiting for triggered
//   POST : collecting trig_pos post-trigger samples
//   DONE : buffer frozen until the host acknowledges with clr_cap_done
//
// Ports
//   clk               system clock
//   rst               synchronous active-high reset
//   start_cap         1-cycle pulse, begins a capture (honoured only in IDLE)
//   trig_pos [AW]     post-trigger sample count, latched when a capture starts
//   smpl_en           sample strobe from the decimator, one sample per high cycle
//   triggered         trigger-logic output, held high until set_capture_done
//   clr_cap_done      host has read the buffer, releases DONE
//   we                RAM write enable
//   waddr [AW]        RAM write address, valid when we=1
//   armed             enough pre-trigger samples stored
//   trig_en           trigger logic enabled (FILL, WAIT, POST)
//   set_capture_done  1-cycle pulse on entry to DONE, clears triggered upstream
//   capture_done      level, capture complete and buffer frozen
//   trace_end [AW]    address of the last sample written
// -----------------------------------------------------------------------------
module capture_ctrl #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_cap,
    input  logic [AW-1:0] trig_pos,
    input  logic          smpl_en,
    input  logic          triggered,
    input  logic          clr_cap_done,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic          armed,
    output logic          trig_en,
    output logic          set_capture_done,
    output logic          capture_done,
    output logic [AW-1:0] trace_end
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StFill = 3'd1;
    localparam logic [2:0] StWait = 3'd2;
    localparam logic [2:0] StPost = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    // Sample counter saturation value and the arming threshold at the adder width.
    localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] DepthSum = (AW+2)'(DEPTH);
    localparam logic [AW:0]   CntOne   = (AW+1)'(1);
    localparam logic [AW-1:0] AddrOne  = AW'(1);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] tp_q, tp_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW:0]   smpl_cnt_q, smpl_cnt_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic          armed_q, armed_d;
    logic          set_done_q, set_done_d;
    logic          cap_done_q, cap_done_d;
    logic [AW-1:0] trace_end_q, trace_end_d;

    logic          active;
    logic          wr;
    logic [AW:0]   smpl_cnt_inc;
    logic [AW+1:0] arm_sum;
    logic          arm_hit;
    logic [AW-1:0] post_cnt_inc;

    // Writing states: the RAM follows the sample strobe directly.
    always_comb begin
        active = (state_q == StFill) || (state_q == StWait) || (state_q == StPost);
        wr     = active && smpl_en;
    end

    // Sample count including this cycle's write, saturating at DEPTH so the
    // arming comparison cannot wrap on long waits for the trigger.
    always_comb begin
        smpl_cnt_inc = smpl_cnt_q;
        if (wr && (smpl_cnt_q != DepthCnt)) begin
            smpl_cnt_inc = smpl_cnt_q + CntOne;
        end
    end

    // Arm once the stored samples leave exactly room for tp post-trigger samples
    // inside DEPTH, so the pre-trigger history is never overwritten.
    always_comb begin
        arm_sum = {1'b0, smpl_cnt_inc} + {2'b00, tp_q};
        arm_hit = (arm_sum >= DepthSum);
    end

    always_comb begin
        post_cnt_inc = post_cnt_q + AddrOne;
    end

    always_comb begin
        state_d     = state_q;
        tp_d        = tp_q;
        waddr_d     = waddr_q;
        smpl_cnt_d  = smpl_cnt_inc;
        post_cnt_d  = post_cnt_q;
        trace_end_d = trace_end_q;
        set_done_d  = 1'b0;

        if (wr) begin
            waddr_d = waddr_q + AddrOne;
        end

        case (state_q)
            StIdle: begin
                if (start_cap) begin
                    state_d    = StFill;
                    tp_d       = trig_pos;
                    waddr_d    = '0;
                    smpl_cnt_d = '0;
                    post_cnt_d = '0;
                end
            end
            StFill: begin
                if (arm_hit) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // A write in the trigger cycle is already counted as pre-trigger.
                if (triggered) begin
                    post_cnt_d = '0;
                    state_d    = (tp_q == '0) ? StDone : StPost;
                end
            end
            StPost: begin
                if (wr) begin
                    post_cnt_d = post_cnt_inc;
                    if (post_cnt_inc == tp_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // start_cap is deliberately not looked at here, even with clr_cap_done.
                if (clr_cap_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // waddr_d already points past the final write, so step back one.
        if ((state_d == StDone) && (state_q != StDone)) begin
            set_done_d  = 1'b1;
            trace_end_d = waddr_d - AddrOne;
        end

        armed_d    = (state_d == StWait) || (state_d == StPost);
        cap_done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tp_q        <= '0;
            waddr_q     <= '0;
            smpl_cnt_q  <= '0;
            post_cnt_q  <= '0;
            armed_q     <= 1'b0;
            set_done_q  <= 1'b0;
            cap_done_q  <= 1'b0;
            trace_end_q <= '0;
        end else begin
            state_q     <= state_d;
            tp_q        <= tp_d;
            waddr_q     <= waddr_d;
            smpl_cnt_q  <= smpl_cnt_d;
            post_cnt_q  <= post_cnt_d;
            armed_q     <= armed_d;
            set_done_q  <= set_done_d;
            cap_done_q  <= cap_done_d;
            trace_end_q <= trace_end_d;
        end
    end

    always_comb begin
        we               = wr;
        waddr            = waddr_q;
        armed            = armed_q;
        trig_en          = active;
        set_capture_done = set_done_q;
        capture_done     = cap_done_q;
        trace_end        = trace_end_q;
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_capture_ctrl
//
// Directed and randomized acquisitions against a count-based reference model.
// The model tracks total writes, whether the capture is armed or triggered, and
// post-trigger writes, and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_capture_ctrl;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic          clk;
    logic          rst;
    logic          start_cap;
    logic [AW-1:0] trig_pos;
    logic          smpl_en;
    logic          triggered;
    logic          clr_cap_done;
    logic          we;
    logic [AW-1:0] waddr;
    logic          armed;
    logic          trig_en;
    logic          set_capture_done;
    logic          capture_done;
    logic [AW-1:0] trace_end;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_cap;
    bit m_armed;
    bit m_trig;
    bit m_done;
    bit m_pulse;
    int n_wr;
    int m_tp;
    int m_post;
    int m_te;

    int cyc      = 0;
    int smpl_div = 1;  // >0: strobe every Nth cycle, 0: random, <0: manual
    int we_seen  = 0;

    capture_ctrl #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_cap       (start_cap),
        .trig_pos        (trig_pos),
        .smpl_en         (smpl_en),
        .triggered       (triggered),
        .clr_cap_done    (clr_cap_done),
        .we              (we),
        .waddr           (waddr),
        .armed           (armed),
        .trig_en         (trig_en),
        .set_capture_done(set_capture_done),
        .capture_done    (capture_done),
        .trace_end       (trace_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("we",               32'(we),               32'(m_cap && smpl_en));
        chk("waddr",            32'(waddr),            32'(n_wr % DEPTH));
        chk("armed",            32'(armed),            32'(m_armed));
        chk("trig_en",          32'(trig_en),          32'(m_cap));
        chk("set_capture_done", 32'(set_capture_done), 32'(m_pulse));
        chk("capture_done",     32'(capture_done),     32'(m_done));
        chk("trace_end",        32'(trace_end),        32'(m_te));
    endtask

    // Advance the model by one clock edge using the inputs held this cycle.
    task automatic model_edge();
        bit fin;
        fin     = 1'b0;
        m_pulse = 1'b0;
        if (rst) begin
            m_cap = 0; m_armed = 0; m_trig = 0; m_done = 0;
            n_wr = 0; m_tp = 0; m_post = 0; m_te = 0;
        end else if (m_cap) begin
            if (smpl_en) n_wr++;
            if (!m_armed) begin
                if (n_wr >= DEPTH - m_tp) m_armed = 1;
            end else if (!m_trig) begin
                if (triggered) begin
                    m_trig = 1;
                    m_post = 0;
                    if (m_tp == 0) fin = 1;
                end
            end else if (smpl_en) begin
                m_post++;
                if (m_post == m_tp) fin = 1;
            end
            if (fin) begin
                m_cap   = 0;
                m_armed = 0;
                m_trig  = 0;
                m_done  = 1;
                m_pulse = 1;
                m_te    = (n_wr + DEPTH - 1) % DEPTH;
            end
        end else if (m_done) begin
            if (clr_cap_done) m_done = 0;
        end else if (start_cap) begin
            m_cap  = 1;
            m_tp   = int'(trig_pos);
            n_wr   = 0;
            m_post = 0;
            m_trig = 0;
        end
    endtask

    task automatic step();
        if (smpl_div > 0) smpl_en = ((cyc % smpl_div) == 0);
        else if (smpl_div == 0) smpl_en = ($urandom_range(0, 2) != 0);
        cyc++;
        @(negedge clk);
        #1;
        check_outputs();
        if (we === 1'b1) we_seen++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic start(input int tp);
        start_cap = 1'b1;
        trig_pos  = AW'(tp);
        step();
        start_cap = 1'b0;
        trig_pos  = AW'($urandom);
    endtask

    task automatic run_until_armed(input int budget);
        for (int i = 0; i < budget && !m_armed; i++) step();
        chk("armed_reached", 32'(armed), 32'd1);
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget && !m_done; i++) step();
        chk("done_reached", 32'(capture_done), 32'd1);
    endtask

    task automatic ack();
        triggered    = 1'b0;
        clr_cap_done = 1'b1;
        step();
        clr_cap_done = 1'b0;
    endtask

    initial begin
        int pre;
        int w0;
        rst = 1'b1; start_cap = 1'b0; trig_pos = '0; smpl_en = 1'b0;
        triggered = 1'b0; clr_cap_done = 1'b0;
        smpl_div = 1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_waddr", 32'(waddr), 32'd0);
        chk("reset_trig_en", 32'(trig_en), 32'd0);

        // 1: tp=100, continuous strobe, trigger on write 600
        smpl_div = 1;
        start(100);
        for (int i = 0; i < 2000 && n_wr < 411; i++) step();
        chk("t1_not_armed_411", 32'(armed), 32'd0);
        step();
        chk("t1_armed_412", 32'(armed), 32'd1);
        for (int i = 0; i < 2000 && n_wr < 599; i++) step();
        triggered = 1'b1;
        step();
        w0 = we_seen;
        run_until_done(2000);
        chk("t1_post_writes", 32'(we_seen - w0), 32'd100);
        chk("t1_trace_end", 32'(trace_end), 32'd187);
        chk("t1_set_done", 32'(set_capture_done), 32'd1);
        triggered = 1'b0;
        step();
        chk("t1_pulse_gone", 32'(set_capture_done), 32'd0);
        chk("t1_done_level", 32'(capture_done), 32'd1);
        ack();

        // 2: tp=0, trigger in WAIT closes the capture at once
        smpl_div = 0;
        start(0);
        run_until_armed(3000);
        triggered = 1'b1;
        step();
        chk("t2_set_done", 32'(set_capture_done), 32'd1);
        chk("t2_trig_en_off", 32'(trig_en), 32'd0);
        chk("t2_trace_end", 32'(trace_end), 32'((n_wr + DEPTH - 1) % DEPTH));
        triggered = 1'b0;
        w0 = we_seen;
        repeat (5) step();
        chk("t2_no_we", 32'(we_seen - w0), 32'd0);
        ack();

        // 3: tp=511 arms after the first write, then exactly 511 post writes
        smpl_div = 1;
        start(511);
        step();
        chk("t3_armed_1st", 32'(armed), 32'd1);
        triggered = 1'b1;
        step();
        w0 = we_seen;
        run_until_done(2000);
        chk("t3_post_writes", 32'(we_seen - w0), 32'd511);
        chk("t3_trace_end", 32'(trace_end), 32'd0);
        ack();

        // 4: 1-in-4 strobe, trigger coincides with a write
        smpl_div = 4;
        start(20);
        run_until_armed(4000);
        for (int i = 0; i < 8 && (cyc % 4) != 0; i++) step();
        triggered = 1'b1;
        step();
        pre = n_wr;
        w0  = we_seen;
        run_until_done(1000);
        chk("t4_post_writes", 32'(we_seen - w0), 32'd20);
        chk("t4_trace_end", 32'(trace_end), 32'((pre + 19) % DEPTH));
        ack();

        // 5: start_cap/trig_pos changes mid-POST ignored; clr+start in DONE
        smpl_div = 1;
        start(30);
        run_until_armed(2000);
        triggered = 1'b1;
        step();
        pre = n_wr;
        w0  = we_seen;
        repeat (5) step();
        start_cap = 1'b1;
        trig_pos  = AW'(5);
        step();
        start_cap = 1'b0;
        run_until_done(1000);
        chk("t5_post_writes", 32'(we_seen - w0), 32'd30);
        chk("t5_trace_end", 32'(trace_end), 32'((pre + 29) % DEPTH));
        triggered = 1'b0;
        step();
        clr_cap_done = 1'b1;
        start_cap    = 1'b1;
        trig_pos     = AW'(7);
        step();
        clr_cap_done = 1'b0;
        start_cap    = 1'b0;
        chk("t5_done_cleared", 32'(capture_done), 32'd0);
        chk("t5_no_restart", 32'(trig_en), 32'd0);
        repeat (3) step();
        chk("t5_still_idle", 32'(trig_en), 32'd0);

        // 6: reset mid-POST, then a clean capture from address 0
        start(200);
        run_until_armed(2000);
        triggered = 1'b1;
        step();
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        triggered = 1'b0;
        chk("t6_rst_we", 32'(we), 32'd0);
        chk("t6_rst_waddr", 32'(waddr), 32'd0);
        chk("t6_rst_armed", 32'(armed), 32'd0);
        chk("t6_rst_trig_en", 32'(trig_en), 32'd0);
        chk("t6_rst_done", 32'(capture_done), 32'd0);
        start(4);
        chk("t6_waddr0", 32'(waddr), 32'd0);
        chk("t6_trig_en", 32'(trig_en), 32'd1);
        run_until_armed(2000);
        step();
        triggered = 1'b1;
        step();
        run_until_done(100);
        chk("t6_trace_end", 32'(trace_end), 32'd1);
        ack();

        // Randomized captures with trigger noise, drops and ignored commands
        for (int r = 0; r < 6; r++) begin
            int tp;
            int dly;
            smpl_div = 0;
            tp  = $urandom_range(0, DEPTH - 1);
            if (r == 0) tp = 0;
            if (r == 1) tp = DEPTH - 1;
            dly = $urandom_range(0, 20);
            start(tp);
            for (int i = 0; i < 6000 && !m_done; i++) begin
                if (!m_armed) begin
                    triggered = ($urandom_range(0, 3) == 0);
                end else if (!m_trig) begin
                    triggered = (dly == 0);
                    if (dly > 0) dly--;
                end else begin
                    triggered = ($urandom_range(0, 1) == 1);
                end
                start_cap    = ($urandom_range(0, 15) == 0);
                trig_pos     = AW'($urandom);
                clr_cap_done = ($urandom_range(0, 15) == 0);
                step();
            end
            start_cap    = 1'b0;
            clr_cap_done = 1'b0;
            triggered    = 1'b0;
            chk("rnd_done", 32'(capture_done), 32'd1);
            repeat ($urandom_range(0, 3)) step();
            ack();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
